pipeline_skid: RTL and testbench
================================

// Module: pipeline_skid
// PURPOSE
// - Valid/ready register slice that breaks the BACKWARD (ready) path: data_in_ready_o is a flop decode,
//   never combinational on data_out_ready_i. Complements the forward-registered pipeline stage.
// - Two storage entries (main + skid) give full throughput with a registered ready.
// - Placed at long-route or high-fanout ready boundaries between core pipeline stages.
// PARAMETERS
// - DW  8   data width
// - CW  16  stall counter width (used only with PIPELINE_SKID_STALL_CNT_EN)
// PORTS
// - clk_i             in   1   clock, rising edge
// - arst_ni           in   1   asynchronous reset, active low
// - clear_i           in   1   synchronous clear, active high
// - data_in_i         in   DW  upstream data
// - data_in_valid_i   in   1   upstream valid
// - data_in_ready_o   out  1   upstream ready (register-driven)
// - data_out_o        out  DW  downstream data (always driven from main entry)
// - data_out_valid_o  out  1   downstream valid
// - data_out_ready_i  in   1   downstream ready
// - stall_count_o     out  CW  present only with PIPELINE_SKID_STALL_CNT_EN
// BEHAVIOUR
// - Handshakes: in_hs = data_in_valid_i & data_in_ready_o; out_hs = data_out_valid_o & data_out_ready_i.
// - States (pipeline_skid_pkg::skid_state_e): EMPTY (0 entries), BUSY (main), FULL (main + skid).
// - data_in_ready_o  = (state != FULL) & arst_ni & ~clear_i.
// - data_out_valid_o = (state != EMPTY) & arst_ni & ~clear_i.
// - Reset: state=EMPTY; ready=0, valid=0 while arst_ni low; ready=1, valid=0 first cycle after release.
// - Data registers have no reset; data_out_o is don't-care while valid=0.
// - Transitions (clear_i has priority, any state -> EMPTY, stored data dropped):
//   EMPTY: in_hs -> BUSY, main<=in.
//   BUSY : in_hs & out_hs -> BUSY, main<=in; in_hs & ~out_hs -> FULL, skid<=in;
//          ~in_hs & out_hs -> EMPTY; else hold.
//   FULL : out_hs -> BUSY, main<=skid; else hold. No input accepted (ready=0).
// - Latency: 1 cycle in->out when EMPTY. Throughput 1 beat/cycle when downstream never stalls.
// - Ordering strictly FIFO; no beat lost or duplicated; skid only written from BUSY with stall.
// - Data held stable on data_out_o while valid & ~ready (AXI-style stability).
// - Reset asserted mid-transfer: outputs drop to 0 immediately (async), contents discarded.
// CONFIGURATION
// - PIPELINE_SKID_STALL_CNT_EN defined: stall_count_o counts cycles with data_out_valid_o &
//   ~data_out_ready_i; saturates at 2**CW-1; reset/clear_i -> 0. Observation only, no datapath effect.
// - Undefined: port and counter absent; CW unused.
// STRUCTURE
// - pipeline_skid_pkg: typedef enum logic [1:0] skid_state_e {EMPTY, BUSY, FULL}.
// - Single flat module; no sub-module. Three always_ff: state (async reset), main/skid data
//   (no reset), optional stall counter (async reset, guarded by macro).
// TESTING
// - Reset release, data_out_ready_i=1, stream 0x01..0x10 back-to-back -> out 0x01..0x10 in order,
//   1-cycle latency, ready never drops.
// - Send 0xA1 then 0xA2 with data_out_ready_i=0 -> state FULL, ready=0 next cycle, data_out_o=0xA1
//   stable; raise ready -> 0xA1 then 0xA2 on consecutive cycles.
// - Random valid (50%) and random ready (30%), 10k beats -> scoreboard exact order, no loss/dup.
// - FULL with 0xB1/0xB2 stored, pulse clear_i one cycle -> valid=0, ready=0 during clear, EMPTY after;
//   0xB1/0xB2 never appear.
// - Drop arst_ni mid-stream with 2 beats held -> valid and ready 0 same cycle; after release ready=1, valid=0.
// - STALL_CNT_EN, CW=4: hold valid with ready=0 for 20 cycles -> stall_count_o saturates at 15.

Source files
------------

// File: rtl/pipeline_skid_pkg.sv
// Shared types for the pipeline_skid register slice.
package pipeline_skid_pkg;

    // Occupancy of the slice: nothing held, main entry only, main plus skid entry.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipeline_skid.sv
// pipeline_skid: valid/ready register slice that registers the backward (ready) path.
// A main entry drives data_out_o. A skid entry absorbs the one beat that can arrive
// while downstream stalls, because the upstream only sees the stall a cycle later.
// Optional feature: define PIPELINE_SKID_STALL_CNT_EN to add a saturating stall counter
// (stall_count_o, CW bits) for observation only.
//
// state | meaning
// EMPTY | no beat held, output invalid
// BUSY  | one beat in main entry
// FULL  | main and skid both hold beats, upstream is back-pressured
module pipeline_skid
    import pipeline_skid_pkg::*;
#(
    parameter int unsigned DW = 8
`ifdef PIPELINE_SKID_STALL_CNT_EN
    ,
    parameter int unsigned CW = 16
`endif
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          clear_i,
    input  logic [DW-1:0] data_in_i,
    input  logic          data_in_valid_i,
    output logic          data_in_ready_o,
    output logic [DW-1:0] data_out_o,
    output logic          data_out_valid_o,
    input  logic          data_out_ready_i
`ifdef PIPELINE_SKID_STALL_CNT_EN
    ,
    output logic [CW-1:0] stall_count_o
`endif
);

    skid_state_e   state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          in_hs, out_hs;

    // Ready depends only on the state flop; reset and clear gate it so nothing is accepted then.
    assign data_in_ready_o  = (state_q != FULL)  & arst_ni & ~clear_i;
    assign data_out_valid_o = (state_q != EMPTY) & arst_ni & ~clear_i;
    assign data_out_o       = main_q;

    assign in_hs  = data_in_valid_i & data_in_ready_o;
    assign out_hs = data_out_valid_o & data_out_ready_i;

    // Next occupancy and entry contents; clear drops whatever is stored.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (clear_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        state_d = BUSY;
                        main_d  = data_in_i;
                    end
                end
                BUSY: begin
                    if (in_hs && out_hs) begin
                        main_d = data_in_i;
                    end else if (in_hs) begin
                        state_d = FULL;
                        skid_d  = data_in_i;
                    end else if (out_hs) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data entries carry no reset; their contents are only observed while valid.
    always_ff @(posedge clk_i) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

`ifdef PIPELINE_SKID_STALL_CNT_EN
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a valid beat waits on downstream, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clear_i) begin
            stall_cnt_d = '0;
        end else if (data_out_valid_o && !data_out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_skid.sv
// Self-checking bench for pipeline_skid: a queue model of the two-entry slice is
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_pipeline_skid;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          arst_ni = 1'b0;
    logic          clear_i = 1'b0;
    logic [DW-1:0] data_in_i = '0;
    logic          data_in_valid_i = 1'b0;
    logic          data_in_ready_o;
    logic [DW-1:0] data_out_o;
    logic          data_out_valid_o;
    logic          data_out_ready_i = 1'b0;
`ifdef PIPELINE_SKID_STALL_CNT_EN
    logic [CW-1:0] stall_count_o;
`endif

    pipeline_skid #(
        .DW(DW)
`ifdef PIPELINE_SKID_STALL_CNT_EN
        ,
        .CW(CW)
`endif
    ) dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .clear_i          (clear_i),
        .data_in_i        (data_in_i),
        .data_in_valid_i  (data_in_valid_i),
        .data_in_ready_o  (data_in_ready_o),
        .data_out_o       (data_out_o),
        .data_out_valid_o (data_out_valid_o),
        .data_out_ready_i (data_out_ready_i)
`ifdef PIPELINE_SKID_STALL_CNT_EN
        ,
        .stall_count_o    (stall_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] dut_log[$];
    int            out_cyc[$];
    int            cyc = 0;
    int            first_in = -1;
    int            first_out = -1;
    int            exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model: the slice is a FIFO of depth two; outputs follow from its occupancy.
    always @(negedge clk_i) begin
        logic er;
        logic ev;
        cyc++;
        if (!arst_ni) begin
            mq.delete();
            exp_cnt = 0;
        end
        er = arst_ni && !clear_i && (mq.size() < 2);
        ev = arst_ni && !clear_i && (mq.size() > 0);
        chk("ready", {31'd0, data_in_ready_o}, {31'd0, er});
        chk("valid", {31'd0, data_out_valid_o}, {31'd0, ev});
        if (ev) chk("data", {24'd0, data_out_o}, {24'd0, mq[0]});
`ifdef PIPELINE_SKID_STALL_CNT_EN
        chk("stall_cnt", {28'd0, stall_count_o}, exp_cnt);
`endif
        if (data_in_valid_i && data_in_ready_o && first_in < 0) first_in = cyc;
        if (data_out_valid_o && data_out_ready_i) begin
            dut_log.push_back(data_out_o);
            out_cyc.push_back(cyc);
            if (first_out < 0) first_out = cyc;
        end
        if (!arst_ni || clear_i) begin
            mq.delete();
            exp_cnt = 0;
        end else begin
            if (ev && !data_out_ready_i && exp_cnt < (1 << CW) - 1) exp_cnt++;
            if (ev && data_out_ready_i) void'(mq.pop_front());
            if (er && data_in_valid_i) mq.push_back(data_in_i);
        end
    end

    initial begin
        int rcyc;

        // Reset held, then released.
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_ready", {31'd0, data_in_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, data_out_valid_o}, 32'd0);
        arst_ni = 1'b1;
        #1;
        chk("rel_ready", {31'd0, data_in_ready_o}, 32'd1);
        chk("rel_valid", {31'd0, data_out_valid_o}, 32'd0);
        tick();

        // Back-to-back stream with downstream always ready.
        data_out_ready_i = 1'b1;
        dut_log.delete();
        out_cyc.delete();
        first_in = -1;
        first_out = -1;
        for (int i = 1; i <= 16; i++) begin
            data_in_i = 8'(i);
            data_in_valid_i = 1'b1;
            tick();
        end
        data_in_valid_i = 1'b0;
        repeat (3) tick();
        chk("stream_count", dut_log.size(), 32'd16);
        for (int i = 0; i < 16 && i < dut_log.size(); i++)
            chk("stream_data", {24'd0, dut_log[i]}, i + 1);
        chk("stream_latency", first_out - first_in, 32'd1);
        if (out_cyc.size() == 16) chk("stream_gapless", out_cyc[15] - out_cyc[0], 32'd15);

        // Fill to FULL with downstream stalled, then drain.
        data_out_ready_i = 1'b0;
        dut_log.delete();
        out_cyc.delete();
        data_in_i = 8'hA1; data_in_valid_i = 1'b1; tick();
        data_in_i = 8'hA2; tick();
        data_in_valid_i = 1'b0;
        chk("full_ready", {31'd0, data_in_ready_o}, 32'd0);
        chk("full_data", {24'd0, data_out_o}, 32'hA1);
        repeat (2) tick();
        chk("full_hold", {24'd0, data_out_o}, 32'hA1);
        data_out_ready_i = 1'b1;
        repeat (3) tick();
        chk("drain_count", dut_log.size(), 32'd2);
        if (dut_log.size() == 2) begin
            chk("drain_first", {24'd0, dut_log[0]}, 32'hA1);
            chk("drain_second", {24'd0, dut_log[1]}, 32'hA2);
            chk("drain_consec", out_cyc[1] - out_cyc[0], 32'd1);
        end

        // Clear while FULL drops both stored beats.
        data_out_ready_i = 1'b0;
        data_in_i = 8'hB1; data_in_valid_i = 1'b1; tick();
        data_in_i = 8'hB2; tick();
        data_in_valid_i = 1'b0;
        dut_log.delete();
        clear_i = 1'b1;
        #1;
        chk("clr_valid", {31'd0, data_out_valid_o}, 32'd0);
        chk("clr_ready", {31'd0, data_in_ready_o}, 32'd0);
        tick();
        clear_i = 1'b0;
        #1;
        chk("post_clr_ready", {31'd0, data_in_ready_o}, 32'd1);
        chk("post_clr_valid", {31'd0, data_out_valid_o}, 32'd0);
        data_out_ready_i = 1'b1;
        repeat (3) tick();
        chk("clr_no_beats", dut_log.size(), 32'd0);

        // Async reset with two beats held.
        data_out_ready_i = 1'b0;
        data_in_i = 8'hC1; data_in_valid_i = 1'b1; tick();
        data_in_i = 8'hC2; tick();
        data_in_i = 8'hC3;
        #1;
        arst_ni = 1'b0;
        #1;
        chk("arst_valid", {31'd0, data_out_valid_o}, 32'd0);
        chk("arst_ready", {31'd0, data_in_ready_o}, 32'd0);
        data_in_valid_i = 1'b0;
        tick();
        dut_log.delete();
        arst_ni = 1'b1;
        #1;
        chk("arst_rel_ready", {31'd0, data_in_ready_o}, 32'd1);
        chk("arst_rel_valid", {31'd0, data_out_valid_o}, 32'd0);
        data_out_ready_i = 1'b1;
        repeat (3) tick();
        chk("arst_no_beats", dut_log.size(), 32'd0);

        // Long stall: counter saturates when the feature is built in.
        data_out_ready_i = 1'b0;
        data_in_i = 8'hD1; data_in_valid_i = 1'b1; tick();
        data_in_valid_i = 1'b0;
        repeat (20) tick();
`ifdef PIPELINE_SKID_STALL_CNT_EN
        chk("stall_sat", {28'd0, stall_count_o}, 32'd15);
`endif
        chk("stall_hold", {24'd0, data_out_o}, 32'hD1);
        data_out_ready_i = 1'b1;
        repeat (2) tick();

        // Random traffic: 50% valid, 30% ready, order checked by the model each cycle.
        dut_log.delete();
        rcyc = 0;
        while (dut_log.size() < 10000 && rcyc < 60000) begin
            data_in_valid_i = 1'($urandom_range(0, 1));
            data_in_i = 8'($urandom_range(0, 255));
            data_out_ready_i = ($urandom_range(0, 9) < 3);
            tick();
            rcyc++;
        end
        chk("rand_budget", {31'd0, rcyc < 60000}, 32'd1);
        data_in_valid_i = 1'b0;
        data_out_ready_i = 1'b1;
        repeat (4) tick();
        chk("rand_drained", mq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
